exa_crosb_input_vc_buffer: RTL and testbench
============================================

// Module: exa_crosb_input_vc_buffer
// PURPOSE
//  Per-input-port buffer directly upstream of the crossbar demux.
//  - Stores incoming flits in two virtual-channel FIFOs (VC0 low prio, VC1 high prio).
//  - Selects one packet at a time and decodes its destination output from the head flit.
//  - Presents the packet's flits with a stable SEL_o until LAST, paced by the input arbiter's clear-to-send.
// PARAMETERS
//  data_width     128                   flit width in bits
//  output_num     16                    crossbar outputs; range of SEL_o
//  sel_width      $clog2(output_num)    width of SEL_o / destination field
//  fifo_depth     16                    flits per VC FIFO; power of 2, >=2
//  dest_lsb       0                     LSB of destination field inside head flit
//  max_hi_burst   4                     consecutive VC1 packets allowed while VC0 waits
// PORTS
//  ACLK           in   1               clock
//  ARESETN        in   1               synchronous active-low reset
//  IN_DATA_i      in   data_width      ingress flit
//  IN_VALID_i     in   1               ingress flit valid
//  IN_LAST_i      in   1               ingress last flit of packet
//  IN_PRIO_i      in   1               ingress VC (1=high); meaningful on head flit only
//  IN_READY_o     out  1               ingress accept
//  CTS_i          in   1               input arbiter grants transfer of current flit
//  DATA_o         out  data_width      flit to demux
//  VALID_o        out  1               flit valid to demux
//  LAST_o         out  1               last flit of packet
//  PRIO_o         out  1               VC of packet in flight
//  SEL_o          out  sel_width       destination output, held stable for whole packet
// BEHAVIOUR
//  Reset: ARESETN=0 at posedge -> FIFOs emptied, partial packets discarded,
//   FSM=IDLE, burst counter=0, ingress VC latch=0.
//   VALID_o=0, LAST_o=0, PRIO_o=0, SEL_o=0, DATA_o=0, IN_READY_o=0 during reset cycle.
//   Reset mid-packet needs no recovery; first post-reset flit is a head flit.
//  Ingress:
//   - Push VC v = in_pkt ? vc_latch : IN_PRIO_i.
//   - vc_latch captured on accepted head flit; in_pkt set on head, cleared on accepted LAST.
//   - IN_READY_o = !full[v]. Full FIFO refuses push even if popped same cycle.
//   - Transfer on IN_VALID_i & IN_READY_o.
//  FIFO:
//   - Registered pointers, count width $clog2(fifo_depth)+1.
//   - Written flit visible at head next cycle.
//   - Pointers wrap modulo fifo_depth. Simultaneous push+pop on non-full FIFO keeps count.
//  Egress FSM states IDLE, SEND.
//   IDLE: VALID_o=0. On a FIFO holding a head flit, choose VC:
//    - VC1 if nonempty and (VC0 empty or burst_cnt<max_hi_burst).
//    - Else VC0.
//    On selection: latch SEL_o = head[dest_lsb +: sel_width] and PRIO_o = chosen VC; go to SEND.
//    Dest value >= output_num is passed unchanged; the demux drops it.
//   SEND: VALID_o = !empty[cur_vc]; DATA_o/LAST_o from head of cur_vc.
//    - Pop on VALID_o & CTS_i.
//    - Popping LAST -> IDLE next cycle.
//    - No preemption mid-packet, even by VC1.
//   Burst counter:
//    - Increments on VC1 packet completion while VC0 nonempty, saturating.
//    - Clears on VC0 packet completion or when VC0 empty.
//  Latency: flit into empty buffer at cycle t -> VALID_o at t+2 (t+1 FIFO write, IDLE->SEND).
//   Back-to-back flits of one packet stream at 1/cycle with CTS_i=1.
//   One idle bubble occurs between packets.
//  CTS_i while VALID_o=0 is ignored. SEL_o/PRIO_o hold last value in IDLE.
// STRUCTURE
//  exa_crosb_pkg:
//   - typedef enum {IDLE,SEND} vcb_state_t
//   - typedef logic vc_t
//   - localparam VC_LO=0, VC_HI=1
//  Sub-module exa_crosb_vc_fifo (flop/LUTRAM FIFO with full/empty/count), instanced twice.
//  Top holds ingress VC latch, egress FSM, burst counter.
// TESTING
//  1. Reset, then one 3-flit VC0 packet with dest=5, CTS_i=1:
//     -> VALID_o 2 cycles after the first push, SEL_o=5 for all 3 flits, LAST_o on the 3rd only, then IDLE.
//  2. Fill VC0 with 16 flits, CTS_i=0:
//     -> IN_READY_o=0 for VC0 pushes. A VC1 head is still accepted.
//     -> Push+pop on full FIFO refused.
//  3. VC0 packet in SEND, VC1 packet arrives:
//     -> VC0 completes uninterrupted.
//     -> Next selection is VC1 with PRIO_o=1.
//  4. Continuous VC1 traffic plus pending VC0 packet, max_hi_burst=4:
//     -> exactly 4 VC1 packets, then 1 VC0 packet, counter cleared.
//  5. CTS_i toggled 1,0,1,0 mid-packet:
//     -> one flit popped per CTS_i=1 cycle; DATA_o and SEL_o stable during CTS_i=0.
//  6. ARESETN low mid-packet, both FIFOs partly full:
//     -> all outputs 0 next cycle. After release, the next packet routes correctly with no stale flits.

Source files
------------

// File: rtl/exa_crosb_pkg.sv
// Shared types for the crossbar input VC buffer: egress FSM states and VC encoding.
package exa_crosb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } vcb_state_t;

    typedef logic vc_t;

    localparam vc_t VC_LO = 1'b0;
    localparam vc_t VC_HI = 1'b1;

endpackage

// File: rtl/exa_crosb_vc_fifo.sv
// Single virtual-channel flit FIFO with registered pointers; head is a
// combinational read of the slot at rd_ptr.
module exa_crosb_vc_fifo #(
    parameter int width = 129,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [$clog2(depth):0] count
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(depth));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    // A full FIFO refuses the push even when the head is leaving this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/exa_crosb_input_vc_buffer.sv
// Per-input-port two-VC flit buffer feeding the crossbar demux; forwards one
// whole packet at a time with a destination select held for the packet.
module exa_crosb_input_vc_buffer
    import exa_crosb_pkg::*;
#(
    parameter int data_width   = 128,
    parameter int output_num   = 16,
    parameter int sel_width    = $clog2(output_num),
    parameter int fifo_depth   = 16,
    parameter int dest_lsb     = 0,
    parameter int max_hi_burst = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [data_width-1:0] IN_DATA_i,
    input  logic                  IN_VALID_i,
    input  logic                  IN_LAST_i,
    input  logic                  IN_PRIO_i,
    output logic                  IN_READY_o,
    input  logic                  CTS_i,
    output logic [data_width-1:0] DATA_o,
    output logic                  VALID_o,
    output logic                  LAST_o,
    output logic                  PRIO_o,
    output logic [sel_width-1:0]  SEL_o
);

    localparam int FW = data_width + 1;
    localparam int CW = $clog2(max_hi_burst + 1);
    localparam int NW = $clog2(fifo_depth) + 1;

    logic                 in_pkt;
    vc_t                  vc_latch;
    vc_t                  push_vc;
    logic                 accept;
    logic [1:0]           push;
    logic [1:0]           pop;
    logic [1:0]           full;
    logic [1:0]           empty;
    logic [1:0][FW-1:0]   head;
    logic [1:0][NW-1:0]   count;

    vcb_state_t           state, next_state;
    vc_t                  cur_vc;
    vc_t                  pick_vc;
    logic                 pick;
    logic                 snd_valid;
    logic                 pkt_done;
    logic [sel_width-1:0] sel_q;
    logic [CW-1:0]        burst_cnt;

    // Body flits follow the VC chosen by their head flit.
    assign push_vc    = in_pkt ? vc_latch : vc_t'(IN_PRIO_i);
    assign IN_READY_o = ARESETN & ~full[push_vc];
    assign accept     = IN_VALID_i & IN_READY_o;
    assign push[VC_LO] = accept & (push_vc == VC_LO);
    assign push[VC_HI] = accept & (push_vc == VC_HI);

    for (genvar g = 0; g < 2; g++) begin : g_vc
        exa_crosb_vc_fifo #(
            .width (FW),
            .depth (fifo_depth)
        ) u_fifo (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .push  (push[g]),
            .wdata ({IN_LAST_i, IN_DATA_i}),
            .pop   (pop[g]),
            .rdata (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g])
        );
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            in_pkt   <= 1'b0;
            vc_latch <= VC_LO;
        end else if (accept) begin
            if (!in_pkt) vc_latch <= vc_t'(IN_PRIO_i);
            in_pkt <= ~IN_LAST_i;
        end
    end

    always_comb begin
        next_state = state;
        pick       = 1'b0;
        pick_vc    = VC_LO;
        pop        = '0;
        snd_valid  = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty[VC_HI] && (empty[VC_LO] || burst_cnt < CW'(max_hi_burst))) begin
                    pick    = 1'b1;
                    pick_vc = VC_HI;
                end else if (!empty[VC_LO]) begin
                    pick    = 1'b1;
                    pick_vc = VC_LO;
                end
                if (pick) next_state = SEND;
            end
            SEND: begin
                snd_valid = ARESETN & ~empty[cur_vc];
                if (snd_valid && CTS_i) begin
                    pop[cur_vc] = 1'b1;
                    if (head[cur_vc][data_width]) begin
                        pkt_done   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= IDLE;
            cur_vc    <= VC_LO;
            sel_q     <= '0;
            burst_cnt <= '0;
        end else begin
            state <= next_state;
            if (pick) begin
                cur_vc <= pick_vc;
                sel_q  <= head[pick_vc][dest_lsb +: sel_width];
            end
            // Burst credit only matters while low-priority traffic is waiting.
            if (empty[VC_LO])
                burst_cnt <= '0;
            else if (pkt_done && cur_vc == VC_LO)
                burst_cnt <= '0;
            else if (pkt_done && burst_cnt < CW'(max_hi_burst))
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    assign VALID_o = snd_valid;
    assign DATA_o  = snd_valid ? head[cur_vc][data_width-1:0] : '0;
    assign LAST_o  = snd_valid & head[cur_vc][data_width];
    assign PRIO_o  = ARESETN & cur_vc;
    assign SEL_o   = ARESETN ? sel_q : '0;

endmodule

// File: tb/tb_exa_crosb_input_vc_buffer.sv
// Directed self-checking bench for the crossbar input VC buffer.
module tb_exa_crosb_input_vc_buffer;

    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          prio;
        logic [3:0]    sel;
    } rec_t;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [DW-1:0] IN_DATA_i;
    logic          IN_VALID_i;
    logic          IN_LAST_i;
    logic          IN_PRIO_i;
    logic          IN_READY_o;
    logic          CTS_i;
    logic [DW-1:0] DATA_o;
    logic          VALID_o;
    logic          LAST_o;
    logic          PRIO_o;
    logic [3:0]    SEL_o;

    int   checks = 0;
    int   errors = 0;
    rec_t got[$];
    rec_t exp_q[$];

    exa_crosb_input_vc_buffer dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .IN_DATA_i  (IN_DATA_i),
        .IN_VALID_i (IN_VALID_i),
        .IN_LAST_i  (IN_LAST_i),
        .IN_PRIO_i  (IN_PRIO_i),
        .IN_READY_o (IN_READY_o),
        .CTS_i      (CTS_i),
        .DATA_o     (DATA_o),
        .VALID_o    (VALID_o),
        .LAST_o     (LAST_o),
        .PRIO_o     (PRIO_o),
        .SEL_o      (SEL_o)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [DW-1:0] fl(input logic [31:0] tag, input logic [3:0] d);
        return {92'd0, tag, d};
    endfunction

    function automatic rec_t rec(input logic [31:0] tag, input logic [3:0] d,
                                 input logic last, input logic prio);
        rec_t r;
        r.data = fl(tag, d);
        r.last = last;
        r.prio = prio;
        r.sel  = d;
        return r;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_in();
        IN_VALID_i = 1'b0;
        IN_LAST_i  = 1'b0;
        IN_PRIO_i  = 1'b0;
        IN_DATA_i  = '0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic last, input logic prio);
        int n = 0;
        IN_VALID_i = 1'b1;
        IN_DATA_i  = d;
        IN_LAST_i  = last;
        IN_PRIO_i  = prio;
        #1;
        while (!IN_READY_o && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout ready=%0b required 1", IN_READY_o);
        end
        step();
        idle_in();
    endtask

    task automatic collect(input int n, input int budget);
        int c = 0;
        got.delete();
        CTS_i = 1'b1;
        while (got.size() < n && c < budget) begin
            #1;
            if (VALID_o) got.push_back({DATA_o, LAST_o, PRIO_o, SEL_o});
            step();
            c++;
        end
        CTS_i = 1'b0;
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout got=%0d required %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        CTS_i   = 1'b0;
        idle_in();
        IN_VALID_i = 1'b1;
        step();
        step();
        checks++;
        if ({VALID_o, LAST_o, PRIO_o, SEL_o, IN_READY_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%h required 00", {VALID_o, LAST_o, PRIO_o, SEL_o, IN_READY_o});
        end
        checks++;
        if (DATA_o !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h required 0", DATA_o);
        end
        idle_in();
        ARESETN = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        CTS_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            idle_in();
            if (c < 3) begin
                IN_VALID_i = 1'b1;
                IN_DATA_i  = fl(100 + c, 4'd5);
                IN_LAST_i  = (c == 2);
            end
            #1;
            checks++;
            if (VALID_o !== (c >= 2 && c <= 4)) begin
                errors++;
                $display("FAIL single_valid cyc=%0d got=%0b required %0b", c, VALID_o, (c >= 2 && c <= 4));
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if ({DATA_o, LAST_o, SEL_o} !== {fl(100 + c - 2, 4'd5), (c == 4), 4'd5}) begin
                    errors++;
                    $display("FAIL single_flit cyc=%0d got=%h/%0b/%0d required %h/%0b/5",
                             c, DATA_o, LAST_o, SEL_o, fl(100 + c - 2, 4'd5), (c == 4));
                end
            end
            step();
        end
        CTS_i = 1'b0;
        idle_in();
    endtask

    task automatic test_full();
        CTS_i = 1'b0;
        for (int i = 0; i < 16; i++) push(fl(200 + i, 4'd1), (i == 15), 1'b0);
        IN_VALID_i = 1'b1;
        IN_DATA_i  = fl(299, 4'd1);
        IN_LAST_i  = 1'b1;
        IN_PRIO_i  = 1'b0;
        #1;
        checks++;
        if (IN_READY_o !== 1'b0) begin
            errors++;
            $display("FAIL full_vc0_ready got=%0b required 0", IN_READY_o);
        end
        IN_DATA_i = fl(300, 4'd6);
        IN_PRIO_i = 1'b1;
        #1;
        checks++;
        if (IN_READY_o !== 1'b1) begin
            errors++;
            $display("FAIL full_vc1_ready got=%0b required 1", IN_READY_o);
        end
        step();
        IN_DATA_i = fl(299, 4'd1);
        IN_PRIO_i = 1'b0;
        CTS_i     = 1'b1;
        #1;
        checks++;
        if ({IN_READY_o, VALID_o} !== 2'b01) begin
            errors++;
            $display("FAIL full_pushpop ready,valid got=%b required 01", {IN_READY_o, VALID_o});
        end
        step();
        idle_in();
        CTS_i = 1'b0;
        #1;
        checks++;
        if (IN_READY_o !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop_ready got=%0b required 1", IN_READY_o);
        end
        exp_q.delete();
        for (int i = 1; i < 16; i++) exp_q.push_back(rec(200 + i, 4'd1, (i == 15), 1'b0));
        exp_q.push_back(rec(300, 4'd6, 1'b1, 1'b1));
        collect(exp_q.size(), 60);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_drain idx=%0d got=%h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_no_preempt();
        CTS_i = 1'b0;
        for (int i = 0; i < 3; i++) push(fl(400 + i, 4'd2), (i == 2), 1'b0);
        push(fl(410, 4'd9), 1'b0, 1'b1);
        push(fl(411, 4'd9), 1'b1, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(rec(400 + i, 4'd2, (i == 2), 1'b0));
        exp_q.push_back(rec(410, 4'd9, 1'b0, 1'b1));
        exp_q.push_back(rec(411, 4'd9, 1'b1, 1'b1));
        collect(exp_q.size(), 30);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL preempt idx=%0d got=%h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_burst();
        CTS_i = 1'b0;
        for (int p = 0; p < 8; p++) begin
            push(fl(500 + 2 * p, 4'd12), 1'b0, 1'b1);
            push(fl(501 + 2 * p, 4'd12), 1'b1, 1'b1);
        end
        for (int i = 0; i < 4; i++) push(fl(600 + i, 4'd3), (i % 2 == 1), 1'b0);
        // Four VC1 packets, one VC0, four more VC1 after the credit clears, then VC0.
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back(rec(500 + 2 * p, 4'd12, 1'b0, 1'b1));
            exp_q.push_back(rec(501 + 2 * p, 4'd12, 1'b1, 1'b1));
            if (p == 3 || p == 7) begin
                exp_q.push_back(rec(600 + (p / 4) * 2, 4'd3, 1'b0, 1'b0));
                exp_q.push_back(rec(601 + (p / 4) * 2, 4'd3, 1'b1, 1'b0));
            end
        end
        collect(exp_q.size(), 100);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL burst idx=%0d got=%h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cts_toggle();
        logic [4:0] pat;
        int         idx [5];
        int         n;
        pat = 5'b10101;
        idx = '{0, 1, 1, 2, 2};
        CTS_i = 1'b0;
        for (int i = 0; i < 3; i++) push(fl(700 + i, 4'd7), (i == 2), 1'b0);
        n = 0;
        while (!VALID_o && n < 10) begin
            step();
            n++;
        end
        for (int j = 0; j < 5; j++) begin
            CTS_i = pat[j];
            #1;
            checks++;
            if ({VALID_o, DATA_o, LAST_o, SEL_o} !== {1'b1, fl(700 + idx[j], 4'd7), (idx[j] == 2), 4'd7}) begin
                errors++;
                $display("FAIL cts_toggle j=%0d got=%0b/%h/%0b/%0d required 1/%h/%0b/7",
                         j, VALID_o, DATA_o, LAST_o, SEL_o, fl(700 + idx[j], 4'd7), (idx[j] == 2));
            end
            step();
        end
        CTS_i = 1'b0;
        #1;
        checks++;
        if (VALID_o !== 1'b0) begin
            errors++;
            $display("FAIL cts_toggle_end valid got=%0b required 0", VALID_o);
        end
    endtask

    task automatic test_reset_mid();
        CTS_i = 1'b0;
        for (int i = 0; i < 3; i++) push(fl(800 + i, 4'd3), (i == 2), 1'b0);
        push(fl(810, 4'd4), 1'b0, 1'b1);
        push(fl(811, 4'd4), 1'b0, 1'b1);
        ARESETN    = 1'b0;
        IN_VALID_i = 1'b1;
        IN_DATA_i  = fl(899, 4'd8);
        step();
        checks++;
        if ({VALID_o, LAST_o, PRIO_o, SEL_o, IN_READY_o} !== 8'h00 || DATA_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs ctrl=%h data=%h required 00/0",
                     {VALID_o, LAST_o, PRIO_o, SEL_o, IN_READY_o}, DATA_o);
        end
        idle_in();
        ARESETN = 1'b1;
        step();
        push(fl(820, 4'd11), 1'b0, 1'b0);
        push(fl(821, 4'd11), 1'b1, 1'b0);
        collect(2, 20);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== rec(820 + i, 4'd11, (i == 1), 1'b0)) begin
                errors++;
                $display("FAIL reset_mid_pkt idx=%0d got=%h required %h", i, got[i], rec(820 + i, 4'd11, (i == 1), 1'b0));
            end
        end
        CTS_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (VALID_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_stale cyc=%0d valid got=%0b required 0", c, VALID_o);
            end
            step();
        end
        CTS_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_full();
        test_no_preempt();
        test_burst();
        test_cts_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
